// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   NUM_REGS / REG_IDX_W : architectural register count and index width
//   src_e                : writeback source (A = single-cycle ALU, B = long-latency unit)
//   wb_tag_t             : destination/source tag carried alongside writeback data
package regfile_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    src_e                 src;
  } wb_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rstn : clock, synchronous active-low reset
//   req[1:0]  : request vector, bit 0 = source A, bit 1 = source B
//   accept    : the current grant is taken this cycle (advances the pointer)
//   grant[1:0]: one-hot combinational grant, forced to zero during reset
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  src_e r_last;
  logic w_pick_a;

  // Under contention the source that did not win last time goes first.
  always_comb begin
    w_pick_a = req[0] && (!req[1] || (r_last == SRC_B));
    grant    = 2'b00;
    if (rstn) begin
      grant[0] = w_pick_a;
      grant[1] = req[1] && !w_pick_a;
    end
  end

  // Reset leaves B as last winner so A wins the first contention.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last <= SRC_B;
    end else if (accept && (grant != 2'b00)) begin
      r_last <= grant[1] ? SRC_B : SRC_A;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler with a pending-write scoreboard.
//   clk, rstn                    : clock, synchronous active-low reset
//   a_valid/a_rd/a_data, a_ready : source A writeback request / accept
//   b_valid/b_rd/b_data, b_ready : source B writeback request / accept
//   issue_valid/issue_rd         : long-latency issue marking rd pending
//   issue_ready                  : issue accepted (rd is 0 or not already pending)
//   rs1/rs2/rd_chk, hazard       : decode-stage hazard lookup (combinational)
//   wb_en/wb_rd/wb_data          : registered register-file write port
//   busy_vec                     : scoreboard, bit n = register n pending
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 a_valid,
  input  logic [REG_IDX_W-1:0] a_rd,
  input  logic [XLEN-1:0]      a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [REG_IDX_W-1:0] b_rd,
  input  logic [XLEN-1:0]      b_data,
  output logic                 b_ready,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd_chk,
  output logic                 hazard,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [1:0]          w_grant;
  logic                w_accept;
  logic                w_issue_acc;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_wb_en;
  wb_tag_t             r_wb_tag;
  logic [XLEN-1:0]     r_wb_data;
  logic [NUM_REGS-1:0] r_busy;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    ({b_valid, a_valid}),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // Grants imply valid, so any grant is an acceptance.
  assign w_accept = w_grant != 2'b00;
  assign a_ready  = w_grant[0];
  assign b_ready  = w_grant[1];

  // WAW block: a second long-latency op may not target a still-pending register.
  assign issue_ready = rstn && ((issue_rd == '0) || !r_busy[issue_rd]);
  assign w_issue_acc = issue_valid && issue_ready;

  assign hazard = r_busy[rs1] || r_busy[rs2] || r_busy[rd_chk];

  // Clear on a B writeback, then set on issue so a same-edge set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wb_en && (r_wb_tag.src == SRC_B)) begin
      w_busy_nxt[r_wb_tag.rd] = 1'b0;
    end
    if (w_issue_acc && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Writeback stage: rd/data hold when idle; writes to x0 update rd/data but never enable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wb_en   <= 1'b0;
      r_wb_tag  <= '{rd: '0, src: SRC_A};
      r_wb_data <= '0;
    end else if (w_accept) begin
      if (w_grant[0]) begin
        r_wb_en   <= a_rd != '0;
        r_wb_tag  <= '{rd: a_rd, src: SRC_A};
        r_wb_data <= a_data;
      end else begin
        r_wb_en   <= b_rd != '0;
        r_wb_tag  <= '{rd: b_rd, src: SRC_B};
        r_wb_data <= b_data;
      end
    end else begin
      r_wb_en <= 1'b0;
    end
  end

  assign wb_en    = r_wb_en;
  assign wb_rd    = r_wb_tag.rd;
  assign wb_data  = r_wb_data;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic            a_valid, b_valid, issue_valid;
  logic [4:0]      a_rd, b_rd, issue_rd, rs1, rs2, rd_chk;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_ready, b_ready, issue_ready, hazard, wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_scheduler #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk), .hazard(hazard),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0; rd_chk = '0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rstn = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; b_valid = 1'b1; b_rd = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd6;
    #1;
    n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready got %b want 0", a_ready); end
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got %b want 0", b_ready); end
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_issue_ready got %b want 0", issue_ready); end
    tick();
    tick();
    n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
    n_tests++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
    n_tests++; if (wb_data !== 64'd0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    n_tests++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy_vec); end
    set_idle();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h11;
    #1;
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL basic_a_ready got %b want 1", a_ready); end
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL basic_b_ready got %b want 0", b_ready); end
    tick();
    set_idle();
    n_tests++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL basic_wb_en got %b want 1", wb_en); end
    n_tests++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL basic_wb_rd got %0d want 5", wb_rd); end
    n_tests++; if (wb_data !== 64'h11) begin n_fail++; $display("FAIL basic_wb_data got %h want 11", wb_data); end
    tick();
    n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL idle_wb_en got %b want 0", wb_en); end
    n_tests++; if (wb_rd !== 5'd5 || wb_data !== 64'h11) begin
      n_fail++; $display("FAIL idle_hold got rd=%0d data=%h want rd=5 data=11", wb_rd, wb_data);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rd [3];
    exp_rd[0] = 5'd3; exp_rd[1] = 5'd4; exp_rd[2] = 5'd3;
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hA0;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 64'hB0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (a_ready !== (k != 1) || b_ready !== (k == 1)) begin
        n_fail++; $display("FAIL rr_grant[%0d] got a=%b b=%b want a=%b b=%b", k, a_ready, b_ready, k != 1, k == 1);
      end
      tick();
      n_tests++; if (wb_en !== 1'b1 || wb_rd !== exp_rd[k]) begin
        n_fail++; $display("FAIL rr_wb[%0d] got en=%b rd=%0d want en=1 rd=%0d", k, wb_en, wb_rd, exp_rd[k]);
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_issue_ready got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    n_tests++; if (busy_vec !== 32'h80) begin n_fail++; $display("FAIL sb_busy_set got %h want 80", busy_vec); end
    rs1 = 5'd7;
    #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rs1 got %b want 1", hazard); end
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_waw_block got %b want 0", issue_ready); end
    tick();
    issue_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h77;
    #1;
    n_tests++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL sb_b_ready got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    n_tests++; if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h77) begin
      n_fail++; $display("FAIL sb_b_wb got en=%b rd=%0d data=%h want en=1 rd=7 data=77", wb_en, wb_rd, wb_data);
    end
    n_tests++; if (busy_vec !== 32'h80) begin n_fail++; $display("FAIL sb_busy_before_clear got %h want 80", busy_vec); end
    tick();
    n_tests++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL sb_busy_clear got %h want 0", busy_vec); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear got %b want 0", hazard); end
    set_idle();
  endtask

  task automatic test_set_clear_same_edge();
    do_reset();
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
    tick();
    b_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sc_issue_ready got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    n_tests++; if (busy_vec !== 32'h200) begin n_fail++; $display("FAIL sc_busy_kept got %h want 200", busy_vec); end
    rd_chk = 5'd9;
    #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sc_hazard_rdchk got %b want 1", hazard); end
    set_idle();
  endtask

  task automatic test_rd_zero();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h55;
    #1;
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL z_a_ready got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    n_tests++; if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'h55) begin
      n_fail++; $display("FAIL z_wb got en=%b rd=%0d data=%h want en=0 rd=0 data=55", wb_en, wb_rd, wb_data);
    end
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL z_issue_ready got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    n_tests++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL z_busy got %h want 0", busy_vec); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd2; a_data = 64'h22;
    tick();
    a_valid = 1'b0;
    n_tests++; if (busy_vec !== 32'h1000 || wb_en !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got busy=%h en=%b want busy=1000 en=1", busy_vec, wb_en);
    end
    b_valid = 1'b1; b_rd = 5'd12; b_data = 64'hC0;
    rstn = 1'b0;
    #1;
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_b_ready got %b want 0", b_ready); end
    tick();
    n_tests++; if (busy_vec !== 32'd0 || wb_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got busy=%h en=%b want busy=0 en=0", busy_vec, wb_en);
    end
    rstn = 1'b1;
    set_idle();
    tick();
  endtask

  // Randomized traffic against a behavioural model of the scheduler.
  task automatic test_random();
    logic [31:0]     m_busy;
    bit              m_last_b;
    bit              m_wb_en, m_wb_from_b;
    logic [4:0]      m_wb_rd;
    logic [XLEN-1:0] m_wb_data;
    bit              ga, gb, ir, hz;
    logic [4:0]      wrd;
    do_reset();
    m_busy = '0; m_last_b = 1'b1; m_wb_en = 1'b0; m_wb_from_b = 1'b0;
    m_wb_rd = '0; m_wb_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rstn        = ($urandom_range(0, 49) != 0);
      a_valid     = $urandom_range(0, 1) == 1;
      b_valid     = $urandom_range(0, 1) == 1;
      issue_valid = $urandom_range(0, 2) == 0;
      a_rd        = 5'($urandom_range(0, 9));
      b_rd        = 5'($urandom_range(0, 9));
      issue_rd    = 5'($urandom_range(0, 9));
      rs1         = 5'($urandom_range(0, 9));
      rs2         = 5'($urandom_range(0, 9));
      rd_chk      = 5'($urandom_range(0, 9));
      a_data      = {$urandom, $urandom};
      b_data      = {$urandom, $urandom};
      #1;
      ga = rstn && a_valid && (!b_valid || m_last_b);
      gb = rstn && b_valid && !ga;
      ir = rstn && ((issue_rd == 5'd0) || !m_busy[issue_rd]);
      hz = m_busy[rs1] || m_busy[rs2] || m_busy[rd_chk];
      n_tests++; if (a_ready !== ga || b_ready !== gb) begin
        n_fail++; $display("FAIL rnd_grant cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, a_ready, b_ready, ga, gb);
      end
      n_tests++; if (issue_ready !== ir) begin
        n_fail++; $display("FAIL rnd_issue_ready cyc=%0d got %b want %b", cyc, issue_ready, ir);
      end
      n_tests++; if (hazard !== hz) begin
        n_fail++; $display("FAIL rnd_hazard cyc=%0d got %b want %b", cyc, hazard, hz);
      end
      if (!rstn) begin
        m_busy = '0; m_last_b = 1'b1; m_wb_en = 1'b0; m_wb_from_b = 1'b0;
        m_wb_rd = '0; m_wb_data = '0;
      end else begin
        if (m_wb_en && m_wb_from_b) m_busy[m_wb_rd] = 1'b0;
        if (issue_valid && ir && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (ga || gb) begin
          wrd         = ga ? a_rd : b_rd;
          m_wb_rd     = wrd;
          m_wb_data   = ga ? a_data : b_data;
          m_wb_en     = wrd != 5'd0;
          m_wb_from_b = gb;
          m_last_b    = gb;
        end else begin
          m_wb_en = 1'b0;
        end
      end
      tick();
      n_tests++; if (wb_en !== m_wb_en || wb_rd !== m_wb_rd || wb_data !== m_wb_data) begin
        n_fail++; $display("FAIL rnd_wb cyc=%0d got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                           cyc, wb_en, wb_rd, wb_data, m_wb_en, m_wb_rd, m_wb_data);
      end
      n_tests++; if (busy_vec !== m_busy) begin
        n_fail++; $display("FAIL rnd_busy cyc=%0d got %h want %h", cyc, busy_vec, m_busy);
      end
    end
    rstn = 1'b1;
    set_idle();
  endtask

  initial begin
    set_idle();
    rstn = 1'b0;
    test_reset();
    test_basic_write();
    test_round_robin();
    test_scoreboard();
    test_set_clear_same_edge();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the register data width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports a_valid/a_rd/a_data  input  1/5/XLEN  source A (single-cycle ALU) writeback request.
REQ-005 SHALL have port a_ready  output  1  source A request accepted this cycle.
REQ-006 SHALL have ports b_valid/b_rd/b_data  input  1/5/XLEN  source B (long-latency unit) writeback request.
REQ-007 SHALL have port b_ready  output  1  source B request accepted this cycle.
REQ-008 SHALL have ports issue_valid/issue_rd  input  1/5  long-latency op issuing, destination register.
REQ-009 SHALL have port issue_ready  output  1  issue accepted; rd marked busy.
REQ-010 SHALL have ports rs1/rs2/rd_chk  input  5 each  operand and destination indices of the decoding instruction.
REQ-011 SHALL have port hazard  output  1  decoding instruction must stall.
REQ-012 SHALL have ports wb_en/wb_rd/wb_data  output  1/5/XLEN  register file write port drive.
REQ-013 SHALL have port busy_vec  output  32  scoreboard state, bit n = register n pending.

Function
REQ-014 Each source request SHALL be accepted when its valid and ready are both high at a rising edge; at most one acceptance per cycle.
REQ-015 When only one source is valid, that source SHALL be granted (ready high same cycle, combinational from valid).
REQ-016 When both are valid, grant SHALL be round-robin: the source not granted last time wins; last-grant pointer updates only on acceptance.
REQ-017 The accepted request SHALL appear on wb_rd/wb_data exactly 1 cycle after acceptance, with wb_en high for that single cycle.
REQ-018 wb_en SHALL be low when the accepted rd is 0; wb_rd/wb_data still update.
REQ-019 With no acceptance, wb_en SHALL be low next cycle; wb_rd/wb_data hold their previous values.
REQ-020 issue_ready SHALL be high iff issue_rd is 0 or busy_vec[issue_rd] is 0 (WAW block).
REQ-021 An accepted issue with issue_rd != 0 SHALL set busy_vec[issue_rd] at the next edge.
REQ-022 busy_vec[wb_rd] SHALL clear at the edge where wb_en is high and the written value originated from source B.
REQ-023 Set and clear of the same bit at the same edge SHALL leave the bit set.
REQ-024 busy_vec[0] SHALL be constantly 0.
REQ-025 hazard SHALL be combinational: high iff busy_vec[rs1], busy_vec[rs2] or busy_vec[rd_chk] is set.
REQ-026 A source-A write to a busy register SHALL be accepted and written; busy state is unaffected (decode is responsible via hazard).

Reset
REQ-027 While rstn is low at an edge: busy_vec = 0, wb_en = 0, wb_rd = 0, wb_data = 0, last-grant = B (A wins first contention).
REQ-028 During reset cycles a_ready, b_ready and issue_ready SHALL be 0; requests presented are not accepted.
REQ-029 Reset mid-operation SHALL drop any in-flight writeback (wb_en low next cycle) and all pending busy bits.

Structure
REQ-030 Shared package regfile_pkg SHALL hold NUM_REGS = 32, REG_IDX_W = 5 and the source enum {SRC_A, SRC_B}.
REQ-031 The two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (req[1:0], accept, grant[1:0], clk, rstn).

Verification
REQ-032 Reset then a_valid=1, a_rd=5, a_data=0x11 -> a_ready=1; next cycle wb_en=1, wb_rd=5, wb_data=0x11.
REQ-033 A and B valid for 3 cycles (rd 3/4) -> grants A, B, A; wb_rd sequence 3, 4, 3 one cycle later.
REQ-034 Issue rd=7 -> busy_vec[7]=1; rs1=7 gives hazard=1; second issue rd=7 sees issue_ready=0; B write rd=7 -> wb_en pulse, busy_vec[7]=0 after that edge, hazard=0.
REQ-035 Issue rd=9 in the same cycle B's write to rd=9 is on wb -> busy_vec[9] remains 1.
REQ-036 a_rd=0 accepted -> wb_en stays 0; issue rd=0 -> issue_ready=1, busy_vec unchanged.
REQ-037 Issue rd=12, then rstn low one cycle while B request pending -> busy_vec=0, wb_en=0, b_ready=0 during reset.
